// File: rtl/ha_sched_pkg.sv
// Shared types and helpers for the time-shared bit-serial adder scheduler.
package ha_sched_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned NREQ_DEF  = 2;
  localparam int unsigned MAX_NREQ  = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // One-hot grant to the first valid requester at or above ptr, wrapping modulo nreq.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                  input logic [2:0]          ptr,
                                                  input int unsigned         nreq);
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    int unsigned         idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq) begin
        idx = 32'(ptr) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && valid[idx[2:0]]) begin
          grant[idx[2:0]] = 1'b1;
          found           = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/ha_fa_cell.sv
// Full-adder cell built from two half-adder stages and an OR gate; purely combinational.
module ha_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_s, ha0_c, ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ ci;
  assign ha1_c = ha0_s & ci;
  assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/ha_serial_sched.sv
// Round-robin scheduler feeding NREQ operand pairs LSB-first through one shared full-adder cell.
module ha_serial_sched
  import ha_sched_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NREQ  = NREQ_DEF,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, id_q, grant_id, next_ptr;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [NREQ-1:0]  grant;
  logic             load, shift;
  logic             cell_s, cell_co;

  assign grant = NREQ'(rr_pick(MAX_NREQ'(req_valid), 3'(rr_ptr_q), NREQ));

  always_comb begin
    grant_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  assign next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  // The single shared cell; every bit of every request passes through it.
  ha_fa_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (bit_cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      bit_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q       <= req_a[grant_id*WIDTH +: WIDTH];
        b_q       <= req_b[grant_id*WIDTH +: WIDTH];
        sum_q     <= '0;
        carry_q   <= 1'b0;
        bit_cnt_q <= '0;
        id_q      <= grant_id;
      end else if (shift) begin
        a_q       <= a_q >> 1;
        b_q       <= b_q >> 1;
        sum_q     <= {cell_s, sum_q[WIDTH-1:1]};
        carry_q   <= cell_co;
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
      if (state_q == DONE && rsp_ready) rr_ptr_q <= next_ptr;
    end
  end

  // After the last shift the carry register holds the MSB carry-out.
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule
